// File: rtl/stage_buffer_pkg.sv
// stage_buffer_pkg: shared types for the stage buffer.
//   STATE_W  width of the control-state encoding
//   state_t  EMPTY (nothing held), ONE (main valid), FULL (main + skid valid)
package stage_buffer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/stage_buffer_if.sv
// stage_buffer_if: valid/ready handshake bundle around one pipeline stage.
//   in_valid/in_ready/D    upstream side (producer -> stage)
//   out_valid/out_ready/Q  downstream side (stage -> consumer)
//   slave  : view taken by the stage itself
//   master : view taken by the environment driving both sides
interface stage_buffer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Q;

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, Q
    );

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, Q
    );
endinterface

// File: rtl/stage_data_reg.sv
// stage_data_reg: W-bit data register.
//   clk, rst  clock, async active-high reset (loads RST)
//   clr       synchronous clear to RST, wins over en
//   en        load d
//   d, q      data in / registered data out
module stage_data_reg #(
    parameter int           W   = 16,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= RST;
        else if (clr) q <= RST;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: one valid/ready pipeline stage, optionally a two-entry skid
// buffer so in_ready comes straight from a flop.
//   clk, rst     clock, async active-high reset
//   flush        synchronous discard of all held entries
//   bus          stage_buffer_if.slave handshake (D in, Q out)
//   stall_count  saturating count of cycles with out_valid & ~out_ready
module stage_buffer
    import stage_buffer_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] RST  = '0,
    parameter bit           SKID = 1'b1,
    parameter int           CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    stage_buffer_if.slave bus,
    output logic [CW-1:0] stall_count
);

    state_t       state, state_nx;
    logic         out_valid_r, in_ready_r;
    logic         in_fire, out_fire;
    logic         main_en, main_clr, main_from_skid;
    logic         skid_en, skid_clr;
    logic [W-1:0] main_q, skid_q;

    assign bus.out_valid = out_valid_r;
    // main is cleared to RST whenever it empties, so Q reads RST when idle
    assign bus.Q         = main_q;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = out_valid_r & bus.out_ready;

    generate
        if (SKID) begin : g_skid_ready
            assign bus.in_ready = in_ready_r;
        end else begin : g_pass_ready
            // single entry: can refill in the same cycle the entry drains
            assign bus.in_ready = ~out_valid_r | bus.out_ready;
        end
    endgenerate

    // Transition decode; flush overrides any transfer in the same cycle.
    always_comb begin
        state_nx       = state;
        main_en        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = ONE;
                    main_en  = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire && SKID) begin
                        state_nx = FULL;
                        skid_en  = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                FULL: if (out_fire) begin
                    state_nx       = ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            stall_count <= '0;
        end else begin
            state       <= state_nx;
            out_valid_r <= (state_nx != EMPTY);
            in_ready_r  <= (state_nx != FULL);
            if (out_valid_r && !bus.out_ready && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    stage_data_reg #(.W(W), .RST(RST)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .clr (main_clr),
        .d   (main_from_skid ? skid_q : bus.D),
        .q   (main_q)
    );

    generate
        if (SKID) begin : g_skid_reg
            stage_data_reg #(.W(W), .RST(RST)) u_skid (
                .clk (clk),
                .rst (rst),
                .en  (skid_en),
                .clr (skid_clr),
                .d   (bus.D),
                .q   (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = RST;
        end
    endgenerate

endmodule

// File: tb/tb_stage_buffer.sv
module tb_stage_buffer;

    localparam logic [15:0] BUB = 16'hF000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] st1, st0;
    int         checks = 0;
    int         errors = 0;
    bit         chk_on = 1'b0;

    stage_buffer_if #(.W(16)) a1 ();
    stage_buffer_if #(.W(16)) a0 ();

    stage_buffer #(.W(16), .RST(BUB), .SKID(1'b1), .CW(4)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(a1), .stall_count(st1)
    );
    stage_buffer #(.W(16), .RST(BUB), .SKID(1'b0), .CW(4)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(a0), .stall_count(st0)
    );

    always #5 clk = ~clk;

    // Behavioural model: a bounded FIFO per instance (capacity 2 / 1).
    logic [15:0] m1[$];
    logic [15:0] m0[$];
    int          s1 = 0, s0 = 0;

    task automatic model_step();
        bit ov, ir;
        if (rst) begin
            m1.delete(); m0.delete(); s1 = 0; s0 = 0;
            return;
        end
        ov = (m1.size() > 0);
        ir = (m1.size() < 2);
        if (ov && !a1.out_ready && s1 < 15) s1++;
        if (flush) m1.delete();
        else begin
            if (ov && a1.out_ready) void'(m1.pop_front());
            if (a1.in_valid && ir) m1.push_back(a1.D);
        end
        ov = (m0.size() > 0);
        ir = (m0.size() == 0) || a0.out_ready;
        if (ov && !a0.out_ready && s0 < 15) s0++;
        if (flush) m0.delete();
        else begin
            if (ov && a0.out_ready) void'(m0.pop_front());
            if (a0.in_valid && ir) m0.push_back(a0.D);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (!rst && chk_on) begin
            chk("m1.out_valid", 32'(a1.out_valid), 32'(m1.size() > 0));
            chk("m1.Q", 32'(a1.Q), 32'((m1.size() > 0) ? m1[0] : BUB));
            chk("m1.in_ready", 32'(a1.in_ready), 32'(m1.size() < 2));
            chk("m1.stall", 32'(st1), 32'(s1));
            chk("m0.out_valid", 32'(a0.out_valid), 32'(m0.size() > 0));
            chk("m0.Q", 32'(a0.Q), 32'((m0.size() > 0) ? m0[0] : BUB));
            chk("m0.in_ready", 32'(a0.in_ready), 32'((m0.size() == 0) || a0.out_ready));
            chk("m0.stall", 32'(st0), 32'(s0));
        end
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit r, input bit f);
        a1.in_valid = v; a1.D = d; a1.out_ready = r;
        a0.in_valid = v; a0.D = d; a0.out_ready = r;
        flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        #1 rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // reset mid-cycle with an entry held
        drive(1, 16'h1234, 0, 0);
        tick();
        chk("pre_rst_q", 32'(a1.Q), 32'h1234);
        drive(0, 16'h0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_q", 32'(a1.Q), 32'hF000);
        chk("rst_out_valid", 32'(a1.out_valid), 32'd0);
        chk("rst_in_ready", 32'(a1.in_ready), 32'd1);
        chk("rst_stall", 32'(st1), 32'd0);
        rst = 1'b0;

        // streaming 1..4 with no back-pressure
        drive(1, 16'd1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("stream_q", 32'(a1.Q), 32'(i));
            chk("stream_in_ready", 32'(a1.in_ready), 32'd1);
            if (i < 4) drive(1, 16'(i + 1), 1, 0);
            else       drive(0, 16'h0, 1, 0);
        end
        tick();
        chk("stream_drain", 32'(a1.out_valid), 32'd0);

        // back-pressure: 0A, 0B fill, 0C held off until release
        drive(1, 16'h000A, 0, 0); tick();
        chk("bp_q0", 32'(a1.Q), 32'h000A);
        drive(1, 16'h000B, 0, 0); tick();
        chk("bp_full_ready", 32'(a1.in_ready), 32'd0);
        drive(1, 16'h000C, 0, 0); tick();
        chk("bp_hold_ready", 32'(a1.in_ready), 32'd0);
        chk("bp_hold_q", 32'(a1.Q), 32'h000A);
        drive(1, 16'h000C, 1, 0); tick();
        chk("bp_q1", 32'(a1.Q), 32'h000B);
        chk("bp_ready_back", 32'(a1.in_ready), 32'd1);
        tick();
        chk("bp_q2", 32'(a1.Q), 32'h000C);
        drive(0, 16'h0, 1, 0); tick();
        chk("bp_empty", 32'(a1.out_valid), 32'd0);

        // flush from FULL drops the concurrent 33
        drive(1, 16'h0011, 0, 0); tick();
        drive(1, 16'h0022, 0, 0); tick();
        chk("fl_full", 32'(a1.in_ready), 32'd0);
        drive(1, 16'h0033, 0, 1); tick();
        chk("fl_valid", 32'(a1.out_valid), 32'd0);
        chk("fl_q", 32'(a1.Q), 32'hF000);
        drive(0, 16'h0, 1, 0);
        repeat (2) begin
            tick();
            chk("fl_no33", 32'(a1.out_valid), 32'd0);
        end

        // stall counter saturation, unaffected by flush
        rst_pulse();
        drive(1, 16'h0077, 0, 0); tick();
        drive(0, 16'h0, 0, 0);
        repeat (3) tick();
        chk("sat_3", 32'(st1), 32'd3);
        repeat (17) tick();
        chk("sat_15", 32'(st1), 32'd15);
        drive(0, 16'h0, 0, 1); tick();
        chk("sat_flush", 32'(st1), 32'd15);
        drive(0, 16'h0, 0, 0); tick();
        chk("sat_after", 32'(st1), 32'd15);

        // single-entry variant: same-cycle drain and refill
        rst_pulse();
        drive(1, 16'h0044, 0, 0); tick();
        chk("s0_q44", 32'(a0.Q), 32'h0044);
        chk("s0_blocked", 32'(a0.in_ready), 32'd0);
        drive(1, 16'h0055, 1, 0); #1;
        chk("s0_ready_comb", 32'(a0.in_ready), 32'd1);
        tick();
        chk("s0_q55", 32'(a0.Q), 32'h0055);
        chk("s0_valid", 32'(a0.out_valid), 32'd1);
        drive(0, 16'h0, 1, 0); tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 4) > 1,
                  $urandom_range(0, 19) == 0);
            tick();
        end
        drive(0, 16'h0, 1, 0);
        repeat (3) tick();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
